// File: rtl/motion_frame_ctrl.sv
// Per-frame animation controller: waits on the frame-tick counter, then erases,
// steps momentum physics on a 4x4 object, and redraws it through the VGA write port.
module motion_frame_ctrl #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X0 = 78,
  parameter int Y0 = 10,
  parameter int GRAVITY = 1,
  parameter int MAX_V = 7,
  parameter logic [2:0] OBJ_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       push_left,
  input  logic       push_right,
  input  logic       frame_tick,
  output logic       tick_enable,
  output logic       tick_reset,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_ARM, S_WAIT, S_ERASE, S_UPDATE} state_t;

  localparam logic signed [9:0] GRAV = 10'(GRAVITY);
  localparam logic signed [9:0] VMAX = 10'(MAX_V);
  localparam logic signed [9:0] XMAX = 10'(SCREEN_W - 4);
  localparam logic signed [9:0] YMAX = 10'(SCREEN_H - 4);
  localparam logic [7:0] XLIM = 8'(SCREEN_W - 4);
  localparam logic [6:0] YLIM = 7'(SCREEN_H - 4);

  state_t state;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic signed [4:0] vx, vy;
  logic [3:0] cnt, cnt_inc;

  logic signed [9:0] push, vx_sum, vy_sum, vxc, vyc, nx, ny;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [4:0] new_vx, new_vy;

  // Next-frame physics, consumed only on the edge leaving UPDATE.
  always_comb begin
    cnt_inc = cnt + 4'd1;
    push   = $signed({9'd0, push_right}) - $signed({9'd0, push_left});
    vx_sum = $signed({{5{vx[4]}}, vx}) + push;
    vy_sum = $signed({{5{vy[4]}}, vy}) + GRAV;
    vxc = (vx_sum > VMAX) ? VMAX : ((vx_sum < -VMAX) ? -VMAX : vx_sum);
    vyc = (vy_sum > VMAX) ? VMAX : ((vy_sum < -VMAX) ? -VMAX : vy_sum);
    nx = $signed({2'b00, pos_x}) + vxc;
    ny = $signed({3'b000, pos_y}) + vyc;
    new_x  = nx[7:0];
    new_vx = vxc[4:0];
    if (nx < 0) begin
      new_x  = 8'd0;
      new_vx = 5'd0 - vxc[4:0];
    end else if (nx > XMAX) begin
      new_x  = XLIM;
      new_vx = 5'd0 - vxc[4:0];
    end
    new_y  = ny[6:0];
    new_vy = vyc[4:0];
    if (ny < 0) begin
      new_y  = 7'd0;
      new_vy = 5'd0 - vyc[4:0];
    end else if (ny > YMAX) begin
      new_y  = YLIM;
      new_vy = 5'd0 - vyc[4:0];
    end
  end

  // Outputs are set on the same edge that enters a state, so they describe that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pos_x       <= 8'(X0);
      pos_y       <= 7'(Y0);
      vx          <= '0;
      vy          <= '0;
      cnt         <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      tick_enable <= 1'b0;
      tick_reset  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      tick_enable <= 1'b0;
      tick_reset  <= 1'b0;
      busy        <= 1'b1;
      case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_DRAW;
            cnt        <= '0;
            vga_plot   <= 1'b1;
            vga_x      <= pos_x;
            vga_y      <= pos_y;
            vga_colour <= OBJ_COLOUR;
          end else begin
            busy <= 1'b0;
          end
        end
        S_DRAW, S_ERASE: begin
          if (cnt == 4'd15) begin
            if (state == S_DRAW) begin
              state      <= S_ARM;
              tick_reset <= 1'b1;
            end else begin
              state <= S_UPDATE;
            end
          end else begin
            cnt        <= cnt_inc;
            vga_plot   <= 1'b1;
            vga_x      <= pos_x + {6'd0, cnt_inc[1:0]};
            vga_y      <= pos_y + {5'd0, cnt_inc[3:2]};
            vga_colour <= (state == S_DRAW) ? OBJ_COLOUR : BG_COLOUR;
          end
        end
        S_ARM: begin
          state       <= S_WAIT;
          tick_enable <= 1'b1;
        end
        S_WAIT: begin
          if (frame_tick) begin
            state      <= S_ERASE;
            cnt        <= '0;
            vga_plot   <= 1'b1;
            vga_x      <= pos_x;
            vga_y      <= pos_y;
            vga_colour <= BG_COLOUR;
          end else begin
            tick_enable <= 1'b1;
          end
        end
        S_UPDATE: begin
          state      <= S_DRAW;
          cnt        <= '0;
          pos_x      <= new_x;
          pos_y      <= new_y;
          vx         <= new_vx;
          vy         <= new_vy;
          vga_plot   <= 1'b1;
          vga_x      <= new_x;
          vga_y      <= new_y;
          vga_colour <= OBJ_COLOUR;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
